// File: rtl/rip_axi_buffer_if.sv
// AXI4 signal bundle joining the buffer to an upstream master or a downstream slave.
// Latency: none, wires only.
// Backpressure: plain valid/ready per channel; the modport fixes which side drives what.
interface rip_axi_interface #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;
    logic [ID_WIDTH-1:0]     wid;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/rip_axi_buffer.sv
// Generic pointer/count FIFO used for every AXI channel of the buffer.
// Latency: 1 cycle from push to head presented at the out side.
// Backpressure: in_rdy low when full or not enabled; out side holds head until out_rdy.
module rip_axi_buffer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Handshake flags come only from registers, so no input reaches an output combinationally.
    assign in_rdy  = en && (cnt != FULL);
    assign out_vld = (cnt != '0);
    assign empty   = (cnt == '0);
    assign out_dat = mem[rptr];
    assign push    = in_vld && in_rdy;
    assign pop     = out_vld && out_rdy;

    // Storage is not reset: contents are meaningless once the count is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_dat;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end
endmodule

// Five-channel AXI4 buffer between an upstream master (s_axi) and downstream slave (m_axi).
// Latency: 1 cycle per channel, push to presentation on the far side.
// Backpressure: per-channel FIFO ready drops when full; all readies gated until first clock after reset.
module rip_axi_buffer #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int AW_DEPTH   = 2,
    parameter int W_DEPTH    = 4,
    parameter int B_DEPTH    = 2,
    parameter int AR_DEPTH   = 2,
    parameter int R_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    rip_axi_interface.slave         s_axi,
    rip_axi_interface.master        m_axi,
    output logic                    idle
);
    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
    } ax_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic                    last;
    } w_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } b_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_t;

    ax_t  aw_in, aw_out, ar_in, ar_out;
    w_t   w_in, w_out;
    b_t   b_in, b_out;
    r_t   r_in, r_out;
    logic aw_empty, w_empty, b_empty, ar_empty, r_empty;
    logic rst_done;

    // Readies stay low until the first clock edge after reset is released.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    assign idle = rst_done && aw_empty && w_empty && b_empty && ar_empty && r_empty;

    assign aw_in = '{id: s_axi.awid, addr: s_axi.awaddr, len: s_axi.awlen, size: s_axi.awsize,
                     burst: s_axi.awburst, lock: s_axi.awlock, cache: s_axi.awcache,
                     prot: s_axi.awprot, qos: s_axi.awqos, region: s_axi.awregion};
    assign ar_in = '{id: s_axi.arid, addr: s_axi.araddr, len: s_axi.arlen, size: s_axi.arsize,
                     burst: s_axi.arburst, lock: s_axi.arlock, cache: s_axi.arcache,
                     prot: s_axi.arprot, qos: s_axi.arqos, region: s_axi.arregion};
    assign w_in  = '{id: s_axi.wid, data: s_axi.wdata, strb: s_axi.wstrb, last: s_axi.wlast};
    assign b_in  = '{id: m_axi.bid, resp: m_axi.bresp};
    assign r_in  = '{id: m_axi.rid, data: m_axi.rdata, resp: m_axi.rresp, last: m_axi.rlast};

    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awlock,
            m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awregion} = aw_out;
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arlock,
            m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.arregion} = ar_out;
    assign {m_axi.wid, m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out;
    assign {s_axi.bid, s_axi.bresp} = b_out;
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_out;

    rip_axi_buffer_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AW_DEPTH)) u_aw_fifo (
        .clk(clk), .rstn(rstn), .en(rst_done),
        .in_vld(s_axi.awvalid), .in_rdy(s_axi.awready), .in_dat(aw_in),
        .out_vld(m_axi.awvalid), .out_rdy(m_axi.awready), .out_dat(aw_out), .empty(aw_empty));

    rip_axi_buffer_fifo #(.WIDTH($bits(w_t)), .DEPTH(W_DEPTH)) u_w_fifo (
        .clk(clk), .rstn(rstn), .en(rst_done),
        .in_vld(s_axi.wvalid), .in_rdy(s_axi.wready), .in_dat(w_in),
        .out_vld(m_axi.wvalid), .out_rdy(m_axi.wready), .out_dat(w_out), .empty(w_empty));

    rip_axi_buffer_fifo #(.WIDTH($bits(b_t)), .DEPTH(B_DEPTH)) u_b_fifo (
        .clk(clk), .rstn(rstn), .en(rst_done),
        .in_vld(m_axi.bvalid), .in_rdy(m_axi.bready), .in_dat(b_in),
        .out_vld(s_axi.bvalid), .out_rdy(s_axi.bready), .out_dat(b_out), .empty(b_empty));

    rip_axi_buffer_fifo #(.WIDTH($bits(ax_t)), .DEPTH(AR_DEPTH)) u_ar_fifo (
        .clk(clk), .rstn(rstn), .en(rst_done),
        .in_vld(s_axi.arvalid), .in_rdy(s_axi.arready), .in_dat(ar_in),
        .out_vld(m_axi.arvalid), .out_rdy(m_axi.arready), .out_dat(ar_out), .empty(ar_empty));

    rip_axi_buffer_fifo #(.WIDTH($bits(r_t)), .DEPTH(R_DEPTH)) u_r_fifo (
        .clk(clk), .rstn(rstn), .en(rst_done),
        .in_vld(m_axi.rvalid), .in_rdy(m_axi.rready), .in_dat(r_in),
        .out_vld(s_axi.rvalid), .out_rdy(s_axi.rready), .out_dat(r_out), .empty(r_empty));
endmodule
